// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXEC/WB control FSM owning the PC and instruction register.
// Stops permanently on a decoded HALT until reset.
module instr_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        dec_en,
   input  logic        dec_halt,
   output logic [31:0] pc,
   output logic        pc_en,
   input  logic [31:0] pc_nxt,
   output logic        exe_start,
   input  logic        exe_done,
   input  logic        wb_req,
   output logic        rf_we,
   output logic [31:0] retired,
   output logic        halted
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;
   logic [2:0] state, state_nxt;
   logic       wb_flag;
   always_comb begin
      state_nxt = (state == S_IDLE && start)    ? S_FETCH :
                  (state == S_FETCH && imem_ack) ? S_DECODE :
                  (state == S_DECODE)            ? (dec_halt ? S_HALT : S_EXEC) :
                  (state == S_EXEC && exe_done)  ? S_WB :
                  (state == S_WB)                ? S_FETCH : state;
   end
   // exe_start is registered so it marks only the first EXEC cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         pc        <= RESET_PC;
         instr     <= '0;
         retired   <= '0;
         wb_flag   <= 1'b0;
         exe_start <= 1'b0;
      end else begin
         state     <= state_nxt;
         exe_start <= state == S_DECODE && !dec_halt;
         if (state == S_FETCH && imem_ack) instr <= imem_rdata;
         if (state == S_EXEC && exe_done) wb_flag <= wb_req;
         if (state == S_WB) begin
            pc      <= pc_nxt;
            retired <= retired + 32'd1;
         end
      end
   end
   assign imem_req  = state == S_FETCH;
   assign imem_addr = imem_req ? pc : 32'd0;
   assign dec_en    = state == S_DECODE;
   assign pc_en     = state == S_WB;
   assign rf_we     = pc_en && wb_flag;
   assign halted    = state == S_HALT;
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control FSM for the simple CPU core. It owns the program-counter register and instruction register and steps each instruction through FETCH, DECODE, EXEC and WB. It drives the combinational `program_counter` (pc_curr in, pc_nxt out) and `decoder` (en, instr in, halt out) blocks, handshakes with instruction memory and the execute unit, and stops permanently on a decoded HALT.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching; ignored in any other state.
- imem_req  out  1  instruction read request; held until imem_ack.
- imem_addr  out  32  word address, equals pc while imem_req=1, else 0.
- imem_ack  in  1  read complete; imem_rdata valid same cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  instruction register, to decoder.instr.
- dec_en  out  1  decoder enable, to decoder.en.
- dec_halt  in  1  decoder.halt.
- pc  out  32  current PC, to program_counter.pc_curr.
- pc_en  out  1  to program_counter.en.
- pc_nxt  in  32  program_counter.pc_nxt.
- exe_start  out  1  one-cycle pulse starting the execute unit.
- exe_done  in  1  execute unit finished.
- wb_req  in  1  the instruction writes rd; sampled with exe_done.
- rf_we  out  1  register-file write strobe.
- retired  out  32  count of completed non-HALT instructions.
- halted  out  1  core stopped.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT (3-bit encoding; encoding is free).
- IDLE: all strobes 0. If start=1, go to FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack=1, instr<=imem_rdata and go to DECODE. With no ack, wait indefinitely with no timeout.
- DECODE: dec_en=1 for exactly one cycle. Sample dec_halt at the end of the cycle. If 1, go to HALT. If 0, go to EXEC.
- EXEC: exe_start=1 only in the first EXEC cycle.
  - On exe_done=1, latch wb_req into an internal flag and go to WB.
  - exe_done may arrive in the same cycle as exe_start.
- WB: rf_we=flag for one cycle. pc_en=1 and pc<=pc_nxt. retired<=retired+1. Go to FETCH.
- HALT: halted=1 and all strobes 0. Stay until rst. start is ignored.
- The branch/offset choice belongs to program_counter. The sequencer only latches pc_nxt in WB.
- pc and retired wrap modulo 2^32 without a flag (32'hFFFF_FFFF+1 gives 0).
- dec_en stays 0 outside DECODE, so decoder outputs hold stable through EXEC/WB.
- Register-file writes use the decoder rd, which stays valid through WB.

## Timing
- Reset values (asserted asynchronously):
  - state=IDLE, pc=RESET_PC, instr=0, retired=0.
  - imem_req, dec_en, pc_en, exe_start, rf_we and halted all 0.
- All outputs are registered state or decode only state, with no combinational path from inputs.
- Minimum latency is 4 cycles per instruction (FETCH, DECODE, EXEC, WB) when imem_ack and exe_done arrive in their first cycle.
- Each wait cycle for imem_ack or exe_done adds exactly 1 cycle.
- HALT detection costs 2 cycles after the fetch request (FETCH then DECODE). halted is 1 from the next cycle.
  - pc is not advanced and retired is not incremented for HALT.
- Reset mid-operation: outputs drop to reset values immediately. A pending memory or execute transaction is abandoned, and the sequencer ignores a late ack/done while in IDLE.
- Spurious imem_ack outside FETCH or exe_done outside EXEC is ignored.

## Test plan
- Reset, then start=1 for one cycle. Memory acks at once with 32'h0100_0000 (func 0, non-halt); exe_done=1 at once, wb_req=1. Required: rf_we pulses in cycle 4, pc becomes pc_nxt=1, retired=1, and the next FETCH has imem_addr=1.
- imem_ack delayed 3 cycles, exe_done delayed 2. Required: imem_req is held with a stable address, exe_start pulses only once, and the instruction takes 9 cycles.
- Fetch 32'h0700_0000 (func 0, opcode 7) so dec_halt=1. Required: no exe_start, no pc_en, halted=1 after DECODE, retired unchanged, and later start pulses are ignored.
- With program_counter computing a branch, pc_nxt=pc+21'd16 in WB. Required: next imem_addr=pc+16. With wb_req=0, rf_we stays 0.
- Assert rst mid-EXEC, then raise exe_done during reset and after release. Required: outputs at reset values immediately, state IDLE, no rf_we, pc=RESET_PC.
- Preload via RESET_PC=32'hFFFF_FFFF and retire one instruction with pc_nxt=pc+1. Required: pc wraps to 0.
